// File: rtl/bias_accumulate_unit.sv
// Bias accumulate unit: sums per-lane adder-tree partial sums over several
// input-channel passes, adds the layer bias on the final pass, saturates to
// DW bits, optionally applies ReLU and holds one result behind a valid/ready
// output register.
module bias_accumulate_unit #(
  parameter int N_adder_tree = 16,
  parameter int DW           = 18,
  parameter int ACC_W        = 24,
  parameter int CNT_W        = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_adder_tree*DW-1:0] in_data,
  input  logic                       in_last,
  input  logic [N_adder_tree*DW-1:0] bias,
  input  logic                       relu_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_adder_tree*DW-1:0] out_data,
  output logic [CNT_W-1:0]           pass_cnt,
  output logic                       sat_flag
);

  // Saturation bounds expressed in the ACC_W+1 bit sum domain.
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-DW+2){1'b1}}, {(DW-1){1'b0}}};

  logic                    accept;
  logic                    first;
  logic                    last_accept;
  logic [N_adder_tree-1:0] lane_sat;
  logic [DW-1:0]           lane_res [N_adder_tree];
  logic [DW-1:0]           out_lane [N_adder_tree];
  logic signed [ACC_W-1:0] acc      [N_adder_tree];

  // The single output register is the only storage: a held, unconsumed
  // result blocks every input beat.
  assign in_ready    = !(out_valid && !out_ready);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && in_last;
  assign first       = (pass_cnt == '0);

  genvar gi;
  generate
    for (gi = 0; gi < N_adder_tree; gi++) begin : g_lane
      logic signed [DW-1:0]  in_w;
      logic signed [DW-1:0]  bias_w;
      logic signed [ACC_W:0] sum_w;
      logic                  sat_hi;
      logic                  sat_lo;
      logic [DW-1:0]         clip_w;

      assign in_w   = in_data[DW*gi +: DW];
      assign bias_w = bias[DW*gi +: DW];

      // Final-pass sum is one bit wider than the accumulator so the bias
      // addition cannot wrap before saturation is decided.
      assign sum_w = (first ? {(ACC_W+1){1'b0}} : {acc[gi][ACC_W-1], acc[gi]})
                   + {{(ACC_W+1-DW){in_w[DW-1]}}, in_w}
                   + {{(ACC_W+1-DW){bias_w[DW-1]}}, bias_w};

      assign sat_hi = (sum_w > SAT_MAX);
      assign sat_lo = (sum_w < SAT_MIN);
      assign clip_w = sat_hi ? {1'b0, {(DW-1){1'b1}}} :
                      sat_lo ? {1'b1, {(DW-1){1'b0}}} : sum_w[DW-1:0];

      // ReLU acts on the already saturated value.
      assign lane_res[gi] = (relu_en && clip_w[DW-1]) ? '0 : clip_w;
      assign lane_sat[gi] = sat_hi || sat_lo;
      assign out_data[DW*gi +: DW] = out_lane[gi];

      // Lane accumulator: restart on the first pass, wrap freely otherwise,
      // clear once the group has been folded into a result.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          acc[gi] <= '0;
        end else if (accept) begin
          if (in_last)
            acc[gi] <= '0;
          else if (first)
            acc[gi] <= {{(ACC_W-DW){in_w[DW-1]}}, in_w};
          else
            acc[gi] <= acc[gi] + {{(ACC_W-DW){in_w[DW-1]}}, in_w};
        end
      end

      // Lane result register, loaded only by an accepted last beat.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          out_lane[gi] <= '0;
        else if (last_accept)
          out_lane[gi] <= lane_res[gi];
      end
    end
  endgenerate

  // Pass counter: counts non-last beats, sticks at all-ones, restarts per group.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pass_cnt <= '0;
    else if (accept) begin
      if (in_last)
        pass_cnt <= '0;
      else if (pass_cnt != '1)
        pass_cnt <= pass_cnt + 1'b1;
    end
  end

  // Output valid and saturation flag: reload on a last beat (even while the
  // previous result is being consumed), drop when consumed without reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
    end else if (last_accept) begin
      out_valid <= 1'b1;
      sat_flag  <= |lane_sat;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
    end
  end

endmodule
